// File: rtl/pay_pkg.sv
// rtl/pay_pkg.sv - shared types and constants for the payment controller
// Purpose: state encoding, credit width and coin values used by
//          payment_ctrl and change_unit.
// Ports:   none (package)
package pay_pkg;

  localparam int CREDIT_W = 8;

  typedef logic [CREDIT_W-1:0] credit_t;

  localparam credit_t CIEN_VAL   = 8'd1;
  localparam credit_t QUIN_VAL   = 8'd5;
  localparam credit_t CREDIT_MAX = 8'd99;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BREW   = 3'd1,
    ST_CHANGE = 3'd2
  } state_e;

  // True when adding 'add' to 'c' stays within CREDIT_MAX.
  // Computed one bit wider so the sum itself cannot wrap.
  function automatic logic credit_fits(input credit_t c, input credit_t add);
    return ({1'b0, c} + {1'b0, add}) <= {1'b0, CREDIT_MAX};
  endfunction

endpackage

// File: rtl/change_unit.sv
// rtl/change_unit.sv - greedy change payout, one coin request at a time
// Purpose: while enabled, raises ret_quin (credit >= 5) or ret_cien
//          (otherwise), holds it until coin_ack, then reports a
//          decrement pulse with its amount and drops the request for
//          at least one cycle before raising the next one.
// Ports:   clk, rst_n     - clock, asynchronous active-low reset
//          en             - payout enabled (controller is in CHANGE)
//          credit         - current credit from the controller
//          coin_ack       - hopper ejected one coin
//          ret_cien/quin  - registered coin requests (exactly one or none)
//          dec_valid      - credit must be decremented this cycle
//          dec_amt        - amount to decrement (1 or 5)
module change_unit
  import pay_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  credit_t credit,
  input  logic    coin_ack,
  output logic    ret_cien,
  output logic    ret_quin,
  output logic    dec_valid,
  output credit_t dec_amt
);

  logic ret_cien_q, ret_cien_d;
  logic ret_quin_q, ret_quin_d;
  logic req_active;

  assign req_active = ret_cien_q | ret_quin_q;

  // Acks with no outstanding request, or outside CHANGE, are ignored.
  assign dec_valid = en & coin_ack & req_active;
  assign dec_amt   = ret_quin_q ? QUIN_VAL : CIEN_VAL;

  always_comb begin
    ret_cien_d = ret_cien_q;
    ret_quin_d = ret_quin_q;
    if (!en) begin
      ret_cien_d = 1'b0;
      ret_quin_d = 1'b0;
    end else if (dec_valid) begin
      // Drop the request on the ack edge; the next one can only be
      // raised from the idle cycle that follows, using updated credit.
      ret_cien_d = 1'b0;
      ret_quin_d = 1'b0;
    end else if (!req_active && credit != '0) begin
      ret_quin_d = (credit >= QUIN_VAL);
      ret_cien_d = (credit <  QUIN_VAL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_cien_q <= 1'b0;
      ret_quin_q <= 1'b0;
    end else begin
      ret_cien_q <= ret_cien_d;
      ret_quin_q <= ret_quin_d;
    end
  end

  assign ret_cien = ret_cien_q;
  assign ret_quin = ret_quin_q;

endmodule

// File: rtl/payment_ctrl.sv
// rtl/payment_ctrl.sv - vending payment controller (credit, selection, change)
// Purpose: accumulates coin credit, accepts or refuses drink selections,
//          starts the drink sequencer and pays change via change_unit.
// Ports:   clk, rst                  - clock, asynchronous active-low reset
//          coin_cien/coin_quin       - coin inserted pulses (+1 / +5)
//          sel_valid, sel_price      - selection pulse and its price
//          cancel                    - refund request pulse
//          brew_done                 - product delivered pulse
//          coin_ack                  - one change coin ejected pulse
//          credit                    - current credit (registered)
//          start_brew, reject_coin,
//          insufficient              - registered one-cycle pulses
//          ret_cien, ret_quin        - change coin requests (levels)
//          busy, state_out           - status / debug
module payment_ctrl
  import pay_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_cien,
  input  logic          coin_quin,
  input  logic          sel_valid,
  input  logic [7:0]    sel_price,
  input  logic          cancel,
  input  logic          brew_done,
  input  logic          coin_ack,
  output logic [7:0]    credit,
  output logic          start_brew,
  output logic          reject_coin,
  output logic          insufficient,
  output logic          ret_cien,
  output logic          ret_quin,
  output logic          busy,
  output logic [2:0]    state_out
);

  state_e  state_q, state_d;
  credit_t credit_q, credit_d;
  logic    start_brew_q, start_brew_d;
  logic    reject_coin_q, reject_coin_d;
  logic    insufficient_q, insufficient_d;
  logic    busy_q, busy_d;

  logic    coin_any;
  logic    sel_ok;
  logic    chg_en;
  logic    dec_valid;
  credit_t dec_amt;
  credit_t credit_after_dec;

  assign coin_any = coin_cien | coin_quin;
  assign sel_ok   = (sel_price != '0) && (credit_q >= sel_price);
  assign chg_en   = (state_q == ST_CHANGE);

  // Saturate at zero even though the greedy choice never over-draws.
  assign credit_after_dec = (dec_amt > credit_q) ? '0 : credit_q - dec_amt;

  change_unit u_change (
    .clk       (clk),
    .rst_n     (rst),
    .en        (chg_en),
    .credit    (credit_q),
    .coin_ack  (coin_ack),
    .ret_cien  (ret_cien),
    .ret_quin  (ret_quin),
    .dec_valid (dec_valid),
    .dec_amt   (dec_amt)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; priority in IDLE is cancel > sel_valid > coin
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
        if (cancel) begin
          if (credit_q != '0) state_d = ST_CHANGE;
        end else if (sel_valid && sel_ok) begin
          state_d = ST_BREW;
        end
      end
      ST_BREW: begin
        state_d = ST_BREW;
        if (brew_done) state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        state_d = ST_CHANGE;
        if (dec_valid && credit_after_dec == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    credit_d       = credit_q;
    start_brew_d   = 1'b0;
    reject_coin_d  = 1'b0;
    insufficient_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          reject_coin_d = coin_any;
        end else if (sel_valid) begin
          reject_coin_d = coin_any;
          if (sel_ok) begin
            credit_d     = credit_q - sel_price;
            start_brew_d = 1'b1;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (coin_cien && coin_quin) begin
          reject_coin_d = 1'b1;
        end else if (coin_cien) begin
          if (credit_fits(credit_q, CIEN_VAL)) credit_d = credit_q + CIEN_VAL;
          else                                 reject_coin_d = 1'b1;
        end else if (coin_quin) begin
          if (credit_fits(credit_q, QUIN_VAL)) credit_d = credit_q + QUIN_VAL;
          else                                 reject_coin_d = 1'b1;
        end
      end
      ST_BREW: begin
        reject_coin_d = coin_any;
      end
      ST_CHANGE: begin
        reject_coin_d = coin_any;
        if (dec_valid) credit_d = credit_after_dec;
      end
      default: begin
        credit_d = credit_q;
      end
    endcase
    // Registered from the next state so busy lines up with state_out.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q       <= '0;
      start_brew_q   <= 1'b0;
      reject_coin_q  <= 1'b0;
      insufficient_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      credit_q       <= credit_d;
      start_brew_q   <= start_brew_d;
      reject_coin_q  <= reject_coin_d;
      insufficient_q <= insufficient_d;
      busy_q         <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign start_brew   = start_brew_q;
  assign reject_coin  = reject_coin_q;
  assign insufficient = insufficient_q;
  assign busy         = busy_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_payment_ctrl.sv
// tb/tb_payment_ctrl.sv - directed self-checking bench for payment_ctrl
module tb_payment_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_cien = 1'b0;
  logic       coin_quin = 1'b0;
  logic       sel_valid = 1'b0;
  logic [7:0] sel_price = 8'd0;
  logic       cancel = 1'b0;
  logic       brew_done = 1'b0;
  logic       coin_ack = 1'b0;
  logic [7:0] credit;
  logic       start_brew;
  logic       reject_coin;
  logic       insufficient;
  logic       ret_cien;
  logic       ret_quin;
  logic       busy;
  logic [2:0] state_out;

  int tests = 0;
  int fails = 0;

  payment_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .coin_cien    (coin_cien),
    .coin_quin    (coin_quin),
    .sel_valid    (sel_valid),
    .sel_price    (sel_price),
    .cancel       (cancel),
    .brew_done    (brew_done),
    .coin_ack     (coin_ack),
    .credit       (credit),
    .start_brew   (start_brew),
    .reject_coin  (reject_coin),
    .insufficient (insufficient),
    .ret_cien     (ret_cien),
    .ret_quin     (ret_quin),
    .busy         (busy),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given pulses high, then all pulses cleared.
  task automatic drive(input logic ci, input logic qu, input logic sv,
                       input logic [7:0] pr, input logic cn,
                       input logic bd, input logic ak);
    coin_cien = ci; coin_quin = qu; sel_valid = sv; sel_price = pr;
    cancel = cn; brew_done = bd; coin_ack = ak;
    step();
    coin_cien = 0; coin_quin = 0; sel_valid = 0; sel_price = 0;
    cancel = 0; brew_done = 0; coin_ack = 0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!(ret_cien | ret_quin) && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(n < 20), 1);
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_credit", credit, 0);
    chk("rst_state", state_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ret", {ret_cien, ret_quin}, 0);
    rst = 1'b1;
    step();

    // Ignored events in IDLE with zero credit
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("cancel_zero_state", state_out, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("ack_idle_credit", credit, 0);

    // Coins 5,6,7 then buy for 7
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("c24_credit5", credit, 5);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("c24_credit6", credit, 6);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("c24_credit7", credit, 7);
    drive(0, 0, 1, 7, 0, 0, 0);
    chk("c24_start_brew", start_brew, 1);
    chk("c24_credit0", credit, 0);
    chk("c24_state_brew", state_out, 1);
    chk("c24_busy", busy, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("c24_start_brew_pulse", start_brew, 0);
    chk("c29_reject_in_brew", reject_coin, 1);
    chk("c29_credit_in_brew", credit, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("c24_idle", state_out, 0);
    chk("c24_no_ret", {ret_cien, ret_quin}, 0);

    // Credit 6, buy 4, two cien change coins
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("c25_credit6", credit, 6);
    drive(0, 0, 1, 4, 0, 0, 0);
    chk("c25_credit2", credit, 2);
    drive(0, 0, 1, 1, 1, 0, 0);
    chk("c25_sel_ignored_brew", credit, 2);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("c25_change", state_out, 2);
    wait_req("c25_req1_timeout");
    chk("c25_req1", {ret_cien, ret_quin}, 2'b10);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("c25_credit1", credit, 1);
    chk("c25_req_drop", {ret_cien, ret_quin}, 0);
    wait_req("c25_req2_timeout");
    chk("c25_req2", {ret_cien, ret_quin}, 2'b10);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("c25_credit0", credit, 0);
    chk("c25_idle", state_out, 0);

    // Credit 12, cancel: quin, quin, cien, cien
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("c26_credit12", credit, 12);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("c26_change", state_out, 2);
    begin
      logic [3:0] exp_quin = 4'b0011;   // index 0 first
      logic [7:0] exp_cred [4] = '{8'd7, 8'd2, 8'd1, 8'd0};
      for (int i = 0; i < 4; i++) begin
        wait_req($sformatf("c26_req%0d_timeout", i));
        chk($sformatf("c26_req%0d_quin", i), ret_quin, exp_quin[i]);
        chk($sformatf("c26_req%0d_onehot", i), ret_quin ^ ret_cien, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk($sformatf("c26_credit%0d", i), credit, exp_cred[i]);
        chk($sformatf("c26_drop%0d", i), {ret_cien, ret_quin}, 0);
      end
    end
    chk("c26_busy_low", busy, 0);
    chk("c26_idle", state_out, 0);

    // Credit ceiling at 97/98
    for (int i = 0; i < 19; i++) drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("c27_credit97", credit, 97);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("c27_quin_reject", reject_coin, 1);
    chk("c27_credit_still97", credit, 97);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("c27_credit98", credit, 98);
    chk("c27_cien_accept", reject_coin, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("c27_both_reject", reject_coin, 1);
    chk("c27_both_credit", credit, 98);
    step();
    chk("c27_single_pulse", reject_coin, 0);

    // Reset clears credit; insufficient cases at credit 3
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rst2_credit", credit, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0);
    chk("c28_credit3", credit, 3);
    drive(0, 0, 1, 5, 0, 0, 0);
    chk("c28_insuff_price", insufficient, 1);
    chk("c28_credit_still3", credit, 3);
    chk("c28_state_idle", state_out, 0);
    step();
    chk("c28_insuff_pulse", insufficient, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("c28_insuff_zero", insufficient, 1);

    // Priority: sel beats coin (coin rejected), cancel beats coin
    drive(0, 1, 1, 9, 0, 0, 0);
    chk("prio_sel_insuff", insufficient, 1);
    chk("prio_sel_reject", reject_coin, 1);
    chk("prio_sel_credit", credit, 3);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("c29_credit9", credit, 9);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("prio_cancel_state", state_out, 2);
    chk("prio_cancel_reject", reject_coin, 1);
    chk("prio_cancel_credit", credit, 9);
    wait_req("c29_req_timeout");
    chk("c29_ret_quin", ret_quin, 1);

    // Asynchronous reset mid-CHANGE
    rst = 1'b0;
    #2;
    chk("c29_async_credit", credit, 0);
    chk("c29_async_ret_quin", ret_quin, 0);
    chk("c29_async_state", state_out, 0);
    chk("c29_async_busy", busy, 0);
    step();
    rst = 1'b1;
    step();
    step();
    chk("c29_no_refund", {ret_cien, ret_quin}, 0);
    chk("c29_after_state", state_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
